// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer that turns one load/store into one dbus transaction and stalls until it completes.
// Build option MEM_STAGE_CTRL_MISALIGN_EN: misaligned ops abort with out_err instead of being aligned down.
module mem_stage_ctrl #(
  parameter int unsigned WAIT_LIMIT = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_msize,
  input  logic        ex_zeroext,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  output logic        stall,
  output logic        out_valid,
  output logic [63:0] out_rdata,
  output logic        out_err,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  state_t           state;
  logic [63:0]      addr_reg;
  logic [63:0]      data_reg;
  logic [63:0]      rdata_reg;
  logic [2:0]       size_reg;
  logic [2:0]       off_reg;
  logic [7:0]       strobe_reg;
  logic             load_reg;
  logic             zeroext_reg;
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             memop;
  logic             accept;
  logic             misalign;
  logic             timeout;
  logic [2:0]       align_mask;
  logic [2:0]       offset;
  logic [7:0]       base_strobe;
  logic [63:0]      req_addr;
  logic [63:0]      load_sh;
  logic [63:0]      load_ext;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    align_mask  = 3'b111;
    base_strobe = 8'hFF;
    case (ex_msize)
      MSIZE1:  begin align_mask = 3'b000; base_strobe = 8'h01; end
      MSIZE2:  begin align_mask = 3'b001; base_strobe = 8'h03; end
      MSIZE4:  begin align_mask = 3'b011; base_strobe = 8'h0F; end
      MSIZE8:  begin align_mask = 3'b111; base_strobe = 8'hFF; end
      default: ;
    endcase
  end

`ifdef MEM_STAGE_CTRL_MISALIGN_EN
  assign misalign = |(ex_addr[2:0] & align_mask);
  assign offset   = ex_addr[2:0];
  assign req_addr = ex_addr;
`else
  // Without the check, the low address bits are silently dropped to size alignment.
  assign misalign = 1'b0;
  assign offset   = ex_addr[2:0] & ~align_mask;
  assign req_addr = {ex_addr[63:3], offset};
`endif

  assign memop    = ex_valid & (ex_memread | ex_memwrite);
  assign accept   = reset & (state == IDLE) & memop;
  assign cnt_next = cnt_reg + CNT_W'(1);
  assign timeout  = (WAIT_LIMIT != 0) && (cnt_next == CNT_W'(WAIT_LIMIT));

  assign load_sh = dresp_data >> {off_reg, 3'b000};

  always_comb begin
    load_ext = load_sh;
    case (size_reg)
      MSIZE1:  load_ext = {{56{~zeroext_reg & load_sh[7]}},  load_sh[7:0]};
      MSIZE2:  load_ext = {{48{~zeroext_reg & load_sh[15]}}, load_sh[15:0]};
      MSIZE4:  load_ext = {{32{~zeroext_reg & load_sh[31]}}, load_sh[31:0]};
      default: load_ext = load_sh;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_reg    <= '0;
      data_reg    <= '0;
      rdata_reg   <= '0;
      size_reg    <= '0;
      off_reg     <= '0;
      strobe_reg  <= '0;
      load_reg    <= 1'b0;
      zeroext_reg <= 1'b0;
      err_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_reg    <= req_addr;
            data_reg    <= ex_wdata << {offset, 3'b000};
            strobe_reg  <= ex_memwrite ? (base_strobe << offset) : 8'h00;
            size_reg    <= ex_msize;
            off_reg     <= offset;
            load_reg    <= ex_memread;
            zeroext_reg <= ex_zeroext;
            rdata_reg   <= '0;
            cnt_reg     <= '0;
            err_reg     <= misalign;
            state       <= misalign ? DONE : REQ;
          end
        end
        REQ: begin
          cnt_reg <= cnt_next;
          if (dresp_addr_ok && dresp_data_ok) begin
            rdata_reg <= load_reg ? load_ext : 64'd0;
            state     <= DONE;
          end else if (timeout) begin
            err_reg <= 1'b1;
            state   <= DONE;
          end else if (dresp_addr_ok) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_next;
          if (dresp_data_ok) begin
            rdata_reg <= load_reg ? load_ext : 64'd0;
            state     <= DONE;
          end else if (timeout) begin
            err_reg <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall and the non-mem pass-through are combinational so the pipeline reacts in the accept cycle.
  assign stall       = accept | (state == REQ) | (state == WAIT);
  assign out_valid   = (state == DONE) | (reset & (state == IDLE) & ex_valid & ~memop);
  assign out_rdata   = (state == DONE) ? rdata_reg : 64'd0;
  assign out_err     = (state == DONE) & err_reg;
  assign dreq_valid  = (state == REQ);
  assign dreq_addr   = addr_reg;
  assign dreq_size   = size_reg;
  assign dreq_strobe = strobe_reg;
  assign dreq_data   = data_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl built with WAIT_LIMIT=4; expectations are hand-computed.
// Honours MEM_STAGE_CTRL_MISALIGN_EN to choose the misaligned-access expectations.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_memread = 1'b0;
  logic        ex_memwrite = 1'b0;
  logic [2:0]  ex_msize = 3'd0;
  logic        ex_zeroext = 1'b0;
  logic [63:0] ex_addr = '0;
  logic [63:0] ex_wdata = '0;
  logic        stall;
  logic        out_valid;
  logic [63:0] out_rdata;
  logic        out_err;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cycles;

  mem_stage_ctrl #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_msize(ex_msize), .ex_zeroext(ex_zeroext), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .stall(stall), .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] sz, input logic zx,
                          input logic [63:0] a, input logic [63:0] wd);
    ex_valid = 1'b1; ex_memread = rd; ex_memwrite = wr;
    ex_msize = sz; ex_zeroext = zx; ex_addr = a; ex_wdata = wd;
  endtask

  task automatic clear_op();
    ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_msize = 3'd0; ex_zeroext = 1'b0; ex_addr = '0; ex_wdata = '0;
  endtask

  // Accept, single REQ cycle answered with addr_ok&data_ok, DONE in the third cycle.
  task automatic fast_op(input string tag, input logic rd, input logic wr, input logic [2:0] sz,
                         input logic zx, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] resp, input logic [63:0] e_addr, input logic [7:0] e_strb,
                         input logic [63:0] e_data, input logic [63:0] e_rdata);
    drive_op(rd, wr, sz, zx, a, wd);
    #1;
    chk({tag, ".acc_stall"}, stall, 1'b1);
    chk({tag, ".acc_dvalid"}, dreq_valid, 1'b0);
    next();
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = resp;
    #1;
    chk({tag, ".req_dvalid"}, dreq_valid, 1'b1);
    chk({tag, ".req_addr"}, dreq_addr, e_addr);
    chk({tag, ".req_size"}, dreq_size, sz);
    chk({tag, ".req_strobe"}, dreq_strobe, e_strb);
    chk({tag, ".req_data"}, dreq_data, e_data);
    chk({tag, ".req_outvalid"}, out_valid, 1'b0);
    next();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    #1;
    chk({tag, ".done_valid"}, out_valid, 1'b1);
    chk({tag, ".done_stall"}, stall, 1'b0);
    chk({tag, ".done_rdata"}, out_rdata, e_rdata);
    chk({tag, ".done_err"}, out_err, 1'b0);
    next();
    chk({tag, ".no_reaccept"}, dreq_valid, 1'b0);
    chk({tag, ".idle_valid"}, out_valid, 1'b0);
    clear_op();
    $display("txn %s addr=%h rdata=%h", tag, a, out_rdata);
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst.stall", stall, 1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_err", out_err, 1'b0);
    chk("rst.out_rdata", out_rdata, 64'd0);
    chk("rst.dreq_valid", dreq_valid, 1'b0);
    chk("rst.dreq_addr", dreq_addr, 64'd0);
    chk("rst.dreq_strobe", dreq_strobe, 8'h00);
    chk("rst.dreq_data", dreq_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("idle.stall", stall, 1'b0);

    // Non-memory instruction passes straight through.
    ex_valid = 1'b1;
    #1;
    chk("nonmem.out_valid", out_valid, 1'b1);
    chk("nonmem.stall", stall, 1'b0);
    chk("nonmem.rdata", out_rdata, 64'd0);
    chk("nonmem.dvalid", dreq_valid, 1'b0);
    next();
    clear_op();
    $display("txn NOP out_valid same cycle");

    // LD with data_ok two cycles after addr_ok.
    stall_cycles = 0;
    drive_op(1'b1, 1'b0, 3'd3, 1'b0, 64'h0000_0000_8000_1000, 64'd0);
    #1;
    if (stall) stall_cycles++;
    chk("ld.acc_dvalid", dreq_valid, 1'b0);
    next();
    dresp_addr_ok = 1'b1;
    #1;
    if (stall) stall_cycles++;
    chk("ld.req_dvalid", dreq_valid, 1'b1);
    chk("ld.req_addr", dreq_addr, 64'h0000_0000_8000_1000);
    chk("ld.req_strobe", dreq_strobe, 8'h00);
    next();
    dresp_addr_ok = 1'b0;
    #1;
    if (stall) stall_cycles++;
    chk("ld.wait_dvalid", dreq_valid, 1'b0);
    next();
    dresp_data_ok = 1'b1; dresp_data = 64'h1122_3344_5566_7788;
    #1;
    if (stall) stall_cycles++;
    chk("ld.wait2_outvalid", out_valid, 1'b0);
    next();
    dresp_data_ok = 1'b0; dresp_data = '0;
    #1;
    chk("ld.done_valid", out_valid, 1'b1);
    chk("ld.done_stall", stall, 1'b0);
    chk("ld.done_rdata", out_rdata, 64'h1122_3344_5566_7788);
    chk("ld.done_err", out_err, 1'b0);
    chk("ld.stall_cycles", 64'(stall_cycles), 64'd4);
    next();
    chk("ld.no_reaccept", dreq_valid, 1'b0);
    clear_op();
    $display("txn LD addr=0000000080001000 stall_cycles=%0d", stall_cycles);

    // Loads of each width, sign and zero extended; stores with lane shift.
    fast_op("LB",  1, 0, 3'd0, 0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000,
            64'h8000_0003, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF80);
    fast_op("LBU", 1, 0, 3'd0, 1, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000,
            64'h8000_0003, 8'h00, 64'd0, 64'h0000_0000_0000_0080);
    fast_op("LH",  1, 0, 3'd1, 0, 64'h8000_0002, 64'd0, 64'h0000_0000_F00D_0000,
            64'h8000_0002, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_F00D);
    fast_op("LW",  1, 0, 3'd2, 0, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000,
            64'h8000_0004, 8'h00, 64'd0, 64'hFFFF_FFFF_8765_4321);
    fast_op("LWU", 1, 0, 3'd2, 1, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000,
            64'h8000_0004, 8'h00, 64'd0, 64'h0000_0000_8765_4321);
    fast_op("SH",  0, 1, 3'd1, 0, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'hDEAD_BEEF_DEAD_BEEF,
            64'h8000_0006, 8'hC0, 64'hABCD_0000_0000_0000, 64'd0);
    fast_op("SB",  0, 1, 3'd0, 0, 64'h8000_0005, 64'h0000_0000_0000_005A, 64'd0,
            64'h8000_0005, 8'h20, 64'h0000_5A00_0000_0000, 64'd0);
    fast_op("SD",  0, 1, 3'd3, 0, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'd0,
            64'h8000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0);

`ifdef MEM_STAGE_CTRL_MISALIGN_EN
    // Misaligned LW aborts without touching the bus.
    drive_op(1'b1, 1'b0, 3'd2, 1'b0, 64'h8000_0002, 64'd0);
    #1;
    chk("mis.acc_stall", stall, 1'b1);
    chk("mis.acc_dvalid", dreq_valid, 1'b0);
    next();
    #1;
    chk("mis.done_valid", out_valid, 1'b1);
    chk("mis.done_err", out_err, 1'b1);
    chk("mis.done_rdata", out_rdata, 64'd0);
    chk("mis.done_dvalid", dreq_valid, 1'b0);
    chk("mis.done_stall", stall, 1'b0);
    next();
    clear_op();
    $display("txn LW misaligned err=1");
`else
    // Misaligned accesses are forced down to size alignment.
    fast_op("LWmis", 1, 0, 3'd2, 0, 64'h8000_0002, 64'd0, 64'h1111_1111_C0DE_C0DE,
            64'h8000_0000, 8'h00, 64'd0, 64'hFFFF_FFFF_C0DE_C0DE);
    fast_op("SWmis", 0, 1, 3'd2, 0, 64'h8000_0006, 64'h0000_0000_CAFE_F00D, 64'd0,
            64'h8000_0004, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'd0);
`endif

    // Timeout: bus never accepts, abort after four REQ cycles.
    drive_op(1'b1, 1'b0, 3'd3, 1'b0, 64'h8000_2000, 64'd0);
    #1;
    chk("to.acc_stall", stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      next();
      chk($sformatf("to.req%0d_dvalid", i), dreq_valid, 1'b1);
      chk($sformatf("to.req%0d_stall", i), stall, 1'b1);
    end
    next();
    chk("to.done_valid", out_valid, 1'b1);
    chk("to.done_err", out_err, 1'b1);
    chk("to.done_rdata", out_rdata, 64'd0);
    chk("to.done_dvalid", dreq_valid, 1'b0);
    next();
    clear_op();
    dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("to.late_valid", out_valid, 1'b0);
    chk("to.late_dvalid", dreq_valid, 1'b0);
    next();
    dresp_data_ok = 1'b0; dresp_data = '0;
    #1;
    chk("to.late2_valid", out_valid, 1'b0);
    chk("to.late2_stall", stall, 1'b0);
    $display("txn LD timeout err=1");

    // Reset asserted while waiting for data.
    next();
    drive_op(1'b1, 1'b0, 3'd3, 1'b0, 64'h8000_3000, 64'd0);
    next();
    dresp_addr_ok = 1'b1;
    #1;
    chk("rw.req_dvalid", dreq_valid, 1'b1);
    next();
    dresp_addr_ok = 1'b0;
    #1;
    chk("rw.wait_stall", stall, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rw.rst_stall", stall, 1'b0);
    chk("rw.rst_dvalid", dreq_valid, 1'b0);
    chk("rw.rst_valid", out_valid, 1'b0);
    next();
    chk("rw.rst2_valid", out_valid, 1'b0);
    clear_op();
    reset = 1'b1;
    next();
    chk("rw.after_valid", out_valid, 1'b0);
    chk("rw.after_dvalid", dreq_valid, 1'b0);
    $display("txn LD dropped by reset in WAIT");

    // Reset asserted while the request is on the bus.
    drive_op(1'b1, 1'b0, 3'd3, 1'b0, 64'h8000_4000, 64'd0);
    next();
    #1;
    chk("rr.req_dvalid", dreq_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("rr.rst_dvalid", dreq_valid, 1'b0);
    chk("rr.rst_stall", stall, 1'b0);
    next();
    clear_op();
    reset = 1'b1;
    next();
    chk("rr.after_valid", out_valid, 1'b0);
    chk("rr.after_dvalid", dreq_valid, 1'b0);
    $display("txn LD dropped by reset in REQ");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
